// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared types for the NPC memory-port arbiter.
// FSM states, owner ids and the abort read value.
package ysyx_24100005_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } mem_arb_state_e;

  typedef enum logic {
    IFU = 1'b0,
    LSU = 1'b1
  } mem_owner_e;

  localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Two-way round-robin grant, bit 0 = IFU, bit 1 = LSU.
// Ports: req[1:0] in, advance in (grant taken), gnt[1:0] one-hot out.
module ysyx_24100005_rr_arb2
  import ysyx_24100005_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  mem_owner_e last_owner_q;
  mem_owner_e last_owner_d;

  // On a tie the requester not served last wins.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: gnt = (last_owner_q == IFU) ? 2'b10 : 2'b01;
      2'b00: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (advance && (gnt != 2'b00)) begin
      last_owner_d = gnt[1] ? LSU : IFU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= IFU;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one memory port between IFU (read) and LSU (read/write).
// Ports: ifu_*/lsu_* requester handshakes, mem_* memory side, rsp_err.
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                rsp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mem_arb_state_e state_q, state_d;
  mem_owner_e     owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic                mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wmask_q, mem_wmask_d;
  logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
  logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;

  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic              accept;
  logic              timeout;
  logic              done;
  logic              done_err;
  logic [DATA_W-1:0] done_data;

  // Requests are only visible to the arbiter while idle.
  assign arb_req = (state_q == IDLE) ?
                   {lsu_req_valid, ifu_req_valid} : 2'b00;
  assign accept  = |gnt;

  ysyx_24100005_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req),
    .advance (accept),
    .gnt     (gnt)
  );

  assign ifu_req_ready = gnt[0];
  assign lsu_req_ready = gnt[1];

  // Fires on the last allowed REQ/WAIT cycle.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    cnt_d           = cnt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    ifu_rsp_valid_d = 1'b0;
    lsu_rsp_valid_d = 1'b0;
    rsp_err_d       = 1'b0;
    ifu_rdata_d     = ifu_rdata_q;
    lsu_rdata_d     = lsu_rdata_q;
    done            = 1'b0;
    done_err        = 1'b0;
    done_data       = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d         = REQ;
          owner_d         = gnt[1] ? LSU : IFU;
          cnt_d           = '0;
          mem_req_valid_d = 1'b1;
          if (gnt[1]) begin
            mem_addr_d  = lsu_addr;
            mem_wen_d   = lsu_wen;
            mem_wdata_d = lsu_wdata;
            mem_wmask_d = lsu_wmask;
          end else begin
            mem_addr_d  = ifu_addr;
            mem_wen_d   = 1'b0;
            mem_wdata_d = '0;
            mem_wmask_d = '0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = DATA_W'(ERR_RDATA);
        end else if (mem_req_ready) begin
          state_d         = WAIT;
          mem_req_valid_d = 1'b0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rsp_valid) begin
          done      = 1'b1;
          done_data = mem_wen_q ? {DATA_W{1'b0}} : mem_rdata;
        end else if (timeout) begin
          done      = 1'b1;
          done_err  = 1'b1;
          done_data = DATA_W'(ERR_RDATA);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
    if (done) begin
      state_d         = RESP;
      mem_req_valid_d = 1'b0;
      rsp_err_d       = done_err;
      if (owner_q == LSU) begin
        lsu_rsp_valid_d = 1'b1;
        lsu_rdata_d     = done_data;
      end else begin
        ifu_rsp_valid_d = 1'b1;
        ifu_rdata_d     = done_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      owner_q         <= IFU;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      ifu_rsp_valid_q <= 1'b0;
      lsu_rsp_valid_q <= 1'b0;
      rsp_err_q       <= 1'b0;
      ifu_rdata_q     <= '0;
      lsu_rdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      cnt_q           <= cnt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      ifu_rsp_valid_q <= ifu_rsp_valid_d;
      lsu_rsp_valid_q <= lsu_rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      ifu_rdata_q     <= ifu_rdata_d;
      lsu_rdata_q     <= lsu_rdata_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign lsu_rsp_valid = lsu_rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign ifu_rdata     = ifu_rdata_q;
  assign lsu_rdata     = lsu_rdata_q;

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed bench for the NPC memory-port arbiter.
// Each task drives one scenario cycle by cycle and checks inline.
module tb_ysyx_24100005_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_24100005_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rdata     (ifu_rdata),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rdata     (lsu_rdata),
    .rsp_err       (rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    #1;
    n_checks++;
    if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, rsp_err,
         ifu_req_ready, lsu_req_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 000000",
               {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, rsp_err,
                ifu_req_ready, lsu_req_ready});
    end
    n_checks++;
    if ({mem_addr, mem_wen, mem_wdata, mem_wmask} !== 69'b0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h %b %h %h exp all zero",
               mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    n_checks++;
    if ({ifu_rdata, lsu_rdata} !== 64'b0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h %h exp 0 0", ifu_rdata, lsu_rdata);
    end
  endtask

  task automatic test_ifu_read();
    step();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL ifu_ready: got %b exp 10", {ifu_req_ready, lsu_req_ready});
    end
    step();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !==
        {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
      n_fail++;
      $display("FAIL ifu_req_fields: got %b %h %b %h exp 1 80000000 0 0",
               mem_req_valid, mem_addr, mem_wen, mem_wmask);
    end
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_0413;
    #1;
    n_checks++;
    if ({mem_req_valid, ifu_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL ifu_wait: got %b exp 00", {mem_req_valid, ifu_rsp_valid});
    end
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, rsp_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL ifu_rsp: got %b exp 100",
               {ifu_rsp_valid, lsu_rsp_valid, rsp_err});
    end
    n_checks++;
    if (ifu_rdata !== 32'h0000_0413) begin
      n_fail++;
      $display("FAIL ifu_rdata: got %h exp 00000413", ifu_rdata);
    end
    step();
    #1;
    n_checks++;
    if (ifu_rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ifu_pulse: got %b exp 0", ifu_rsp_valid);
    end
  endtask

  task automatic test_lsu_write();
    step();
    lsu_req_valid = 1'b1;
    lsu_addr  = 32'h8000_0100;
    lsu_wen   = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'b0011;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL lsu_ready: got %b exp 01", {ifu_req_ready, lsu_req_ready});
    end
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
        {1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b0011}) begin
      n_fail++;
      $display("FAIL lsu_req_fields: got %b %h %b %h %b exp 1 80000100 1 deadbeef 0011",
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if ({lsu_rsp_valid, ifu_rsp_valid, rsp_err} !== 3'b100) begin
      n_fail++;
      $display("FAIL lsu_rsp: got %b exp 100",
               {lsu_rsp_valid, ifu_rsp_valid, rsp_err});
    end
    n_checks++;
    if ({lsu_rdata, ifu_rdata} !== {32'h0, 32'h0000_0413}) begin
      n_fail++;
      $display("FAIL lsu_wr_rdata: got %h %h exp 00000000 00000413",
               lsu_rdata, ifu_rdata);
    end
    step();
    lsu_wen = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt [4];
    int ng;
    exp_gnt[0] = 2'b10;
    exp_gnt[1] = 2'b01;
    exp_gnt[2] = 2'b10;
    exp_gnt[3] = 2'b01;
    ng = 0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    ifu_addr  = 32'h8000_1000;
    lsu_addr  = 32'h8000_2000;
    lsu_wen   = 1'b0;
    lsu_wmask = 4'hf;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_A5A5;
    for (int c = 0; c < 16; c++) begin
      #1;
      n_checks++;
      if (ifu_req_ready && lsu_req_ready) begin
        n_fail++;
        $display("FAIL rr_onehot: cycle %0d got 11 exp at most one", c);
      end
      if (ifu_req_ready || lsu_req_ready) begin
        if (ng < 4) begin
          n_checks++;
          if ({lsu_req_ready, ifu_req_ready} !== exp_gnt[ng]) begin
            n_fail++;
            $display("FAIL rr_order: grant %0d got %b exp %b",
                     ng, {lsu_req_ready, ifu_req_ready}, exp_gnt[ng]);
          end
        end
        ng++;
      end
      step();
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    n_checks++;
    if (ng !== 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d exp 4", ng);
    end
    n_checks++;
    if ({ifu_rdata, lsu_rdata} !== {32'h0000_A5A5, 32'h0000_A5A5}) begin
      n_fail++;
      $display("FAIL rr_rdata: got %h %h exp 0000a5a5 0000a5a5",
               ifu_rdata, lsu_rdata);
    end
  endtask

  task automatic test_backpressure();
    step();
    lsu_req_valid = 1'b1;
    lsu_addr  = 32'h8000_0200;
    lsu_wen   = 1'b0;
    lsu_wdata = 32'h0;
    lsu_wmask = 4'hf;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_accept: got %b exp 1", lsu_req_ready);
    end
    step();
    lsu_req_valid = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0300;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) mem_req_ready = 1'b1;
      #1;
      n_checks++;
      if ({mem_req_valid, mem_addr, mem_wmask, ifu_req_ready} !==
          {1'b1, 32'h8000_0200, 4'hf, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_req_hold: cycle %0d got %b %h %h %b exp 1 80000200 f 0",
                 c, mem_req_valid, mem_addr, mem_wmask, ifu_req_ready);
      end
      step();
    end
    mem_req_ready = 1'b0;
    for (int c = 5; c <= 6; c++) begin
      #1;
      n_checks++;
      if ({mem_req_valid, ifu_req_ready, lsu_rsp_valid, mem_addr} !==
          {3'b000, 32'h8000_0200}) begin
        n_fail++;
        $display("FAIL bp_wait: cycle %0d got %b %b %b %h exp 0 0 0 80000200",
                 c, mem_req_valid, ifu_req_ready, lsu_rsp_valid, mem_addr);
      end
      step();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if ({lsu_rsp_valid, rsp_err, ifu_req_ready, lsu_rdata} !==
        {3'b100, 32'hCAFE_F00D}) begin
      n_fail++;
      $display("FAIL bp_rsp: got %b %b %b %h exp 1 0 0 cafef00d",
               lsu_rsp_valid, rsp_err, ifu_req_ready, lsu_rdata);
    end
    step();
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_idle: got %b exp 10", {ifu_req_ready, lsu_rsp_valid});
    end
    ifu_req_valid = 1'b0;
  endtask

  task automatic test_watchdog();
    step();
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0400;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_accept: got %b exp 1", ifu_req_ready);
    end
    step();
    ifu_req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_checks++;
      if ({mem_req_valid, ifu_rsp_valid, rsp_err} !== 3'b100) begin
        n_fail++;
        $display("FAIL wd_pending: cycle %0d got %b exp 100",
                 c, {mem_req_valid, ifu_rsp_valid, rsp_err});
      end
      step();
    end
    #1;
    n_checks++;
    if ({ifu_rsp_valid, rsp_err, mem_req_valid, lsu_rsp_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL wd_abort: got %b exp 1100",
               {ifu_rsp_valid, rsp_err, mem_req_valid, lsu_rsp_valid});
    end
    n_checks++;
    if (ifu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL wd_rdata: got %h exp 00000000", ifu_rdata);
    end
    step();
    mem_rsp_valid = 1'b1;
    mem_rdata = 32'h0000_7777;
    step();
    mem_rsp_valid = 1'b0;
    #1;
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_req_valid, ifu_rdata} !==
        {4'b0000, 32'h0}) begin
      n_fail++;
      $display("FAIL wd_late_rsp: got %b %h exp 0000 00000000",
               {ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_req_valid}, ifu_rdata);
    end
  endtask

  task automatic test_reset_mid_wait();
    step();
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_0500;
    lsu_wen  = 1'b0;
    step();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_valid, mem_addr} !== {1'b0, 32'h8000_0500}) begin
      n_fail++;
      $display("FAIL rst_pre: got %b %h exp 0 80000500", mem_req_valid, mem_addr);
    end
    step();
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    n_checks++;
    if ({mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, rsp_err, mem_addr} !==
        {4'b0000, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_outputs: got %b %h exp 0000 00000000",
               {mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, rsp_err}, mem_addr);
    end
    n_checks++;
    if (lsu_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_rdata: got %h exp 00000000", lsu_rdata);
    end
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_tie: got %b exp 10", {lsu_req_ready, ifu_req_ready});
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    step();
    #1;
    n_checks++;
    if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_no_rsp: got %b exp 000",
               {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
    end
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_lsu_write();
    test_round_robin();
    test_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
